bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_if.sv | 27 ++
 rtl/bus_arbiter.sv | 92 +++++++++
 2 files changed

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request/grant and shared-bus signals between three masters and the bus arbiter.
interface bus_arbiter_if;
  logic [2:0]  i_REQ;
  logic [2:0]  o_GNT;
  logic [95:0] i_ADDR;
  logic [95:0] i_WDATA;
  logic [2:0]  i_WE;
  logic [2:0]  i_RE;
  logic [5:0]  i_HB;
  logic [31:0] o_BUS_ADDR;
  logic [31:0] o_BUS_WDATA;
  logic        o_BUS_WE;
  logic        o_BUS_RE;
  logic [1:0]  o_BUS_HB;
  logic [31:0] i_BUS_RDATA;
  logic [31:0] o_RDATA;
  logic [1:0]  o_OWNER;
  logic        o_TIMEOUT;
  modport slave (
    input  i_REQ, i_ADDR, i_WDATA, i_WE, i_RE, i_HB, i_BUS_RDATA,
    output o_GNT, o_BUS_ADDR, o_BUS_WDATA, o_BUS_WE, o_BUS_RE, o_BUS_HB, o_RDATA, o_OWNER, o_TIMEOUT
  );
  modport master (
    output i_REQ, i_ADDR, i_WDATA, i_WE, i_RE, i_HB, i_BUS_RDATA,
    input  o_GNT, o_BUS_ADDR, o_BUS_WDATA, o_BUS_WE, o_BUS_RE, o_BUS_HB, o_RDATA, o_OWNER, o_TIMEOUT
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: 3-master round-robin bus arbiter with registered one-hot grant and owner bus mux.
// Define BUS_ARB_TIMEOUT_EN to bound each ownership to TIMEOUT cycles with forced revoke.
module bus_arbiter #(
  parameter int TIMEOUT = 256
) (
  input logic i_CLK,
  input logic i_RST,
  bus_arbiter_if.slave bus
);
  typedef enum logic {IDLE, OWNED} state_t;
  state_t r_state, w_state;
  logic [2:0] r_gnt, w_gnt;
  logic [1:0] r_owner, w_owner, r_last, w_last;
  logic [1:0] w_c0, w_c1, w_c2, w_win;
  logic [2:0] w_elig, w_own_oh;
  logic [3:0] w_req4, w_we4, w_re4;
  logic w_own_req, w_arb, w_found, w_revoke;
  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("bus_arbiter: TIMEOUT out of range");
  end
  assign w_req4 = {1'b0, bus.i_REQ};
  assign w_we4 = {1'b0, bus.i_WE};
  assign w_re4 = {1'b0, bus.i_RE};
  assign w_own_oh = 3'b001 << r_owner;
  assign w_own_req = (r_state == OWNED) && w_req4[r_owner];
`ifdef BUS_ARB_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic [2:0] r_inelig;
  logic r_timeout;
  assign w_revoke = w_own_req && (r_cnt == 16'(TIMEOUT - 1));
  // The revoked owner is excluded at the very edge it loses the bus
  assign w_elig = bus.i_REQ & ~r_inelig & ~(w_revoke ? w_own_oh : 3'b000);
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_cnt <= '0;
      r_inelig <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_revoke;
      r_inelig <= (r_inelig & bus.i_REQ) | (w_revoke ? w_own_oh : 3'b000);
      r_cnt <= (w_arb && w_found) ? 16'd0 : (r_state == OWNED) ? r_cnt + 16'd1 : r_cnt;
    end
  end
  assign bus.o_TIMEOUT = r_timeout;
`else
  assign w_revoke = 1'b0;
  assign w_elig = bus.i_REQ;
  assign bus.o_TIMEOUT = 1'b0;
`endif
  assign w_arb = (r_state == IDLE) || !w_own_req || w_revoke;
  assign w_c0 = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
  assign w_c1 = (w_c0 == 2'd2) ? 2'd0 : w_c0 + 2'd1;
  assign w_c2 = (w_c1 == 2'd2) ? 2'd0 : w_c1 + 2'd1;
  assign w_found = |w_elig;
  assign w_win = w_elig[w_c0] ? w_c0 : w_elig[w_c1] ? w_c1 : w_c2;
  always_comb begin
    w_state = r_state;
    w_gnt = r_gnt;
    w_owner = r_owner;
    w_last = r_last;
    if (w_arb) begin
      w_state = w_found ? OWNED : IDLE;
      w_owner = w_found ? w_win : 2'd3;
      w_gnt = w_found ? 3'b001 << w_win : 3'b000;
      w_last = w_found ? w_win : r_last;
    end
  end
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_state <= IDLE;
      r_gnt <= '0;
      r_owner <= 2'd3;
      r_last <= 2'd2;
    end else begin
      r_state <= w_state;
      r_gnt <= w_gnt;
      r_owner <= w_owner;
      r_last <= w_last;
    end
  end
  assign bus.o_GNT = r_gnt;
  assign bus.o_OWNER = r_owner;
  assign bus.o_RDATA = bus.i_BUS_RDATA;
  assign bus.o_BUS_ADDR = (r_owner == 2'd0) ? bus.i_ADDR[31:0] : (r_owner == 2'd1) ? bus.i_ADDR[63:32] :
                          (r_owner == 2'd2) ? bus.i_ADDR[95:64] : 32'd0;
  assign bus.o_BUS_WDATA = (r_owner == 2'd0) ? bus.i_WDATA[31:0] : (r_owner == 2'd1) ? bus.i_WDATA[63:32] :
                           (r_owner == 2'd2) ? bus.i_WDATA[95:64] : 32'd0;
  assign bus.o_BUS_HB = (r_owner == 2'd0) ? bus.i_HB[1:0] : (r_owner == 2'd1) ? bus.i_HB[3:2] :
                        (r_owner == 2'd2) ? bus.i_HB[5:4] : 2'd0;
  assign bus.o_BUS_WE = w_we4[r_owner] & w_req4[r_owner];
  assign bus.o_BUS_RE = w_re4[r_owner] & w_req4[r_owner];
endmodule
